// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multi-cycle MIPS sequencer: states, opcodes and
// datapath mux-select constants, plus the DECODE dispatch function.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_EXEC_I   = 4'd10,
    S_I_WB     = 4'd11,
    S_HALT     = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_SLTI  = 6'h0A;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_FUNC = 2'b10;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic state_t decode_next(input logic [5:0] op);
    case (op)
      OP_RTYPE:                         return S_EXEC_R;
      OP_LW, OP_SW:                     return S_MEM_ADDR;
      OP_BEQ, OP_BNE:                   return S_BRANCH;
      OP_J:                             return S_JUMP;
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: return S_EXEC_I;
      default:                          return S_HALT;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_out.sv
// Combinational control-word decode from the current state; only pc_write,
// ir_write and instr_done look at mem_ready/zero in the same cycle.
module multicycle_ctrl_out
  import multicycle_control_pkg::*;
(
  input  logic       rst,
  input  state_t     state,
  input  logic [5:0] op_q,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic [1:0] alu_sel,
  output logic       instr_done
);

  always_comb begin
    pc_write   = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RT;
    pc_source  = PCSRC_ALU;
    alu_sel    = ALU_ADD;
    instr_done = 1'b0;
    // Reset overrides the state decode so no access or write leaks out.
    if (!rst) begin
      case (state)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = SRCB_FOUR;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE:   alu_src_b = SRCB_IMM_SH;
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
        end
        S_MEM_RD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
        end
        S_MEM_WR: begin
          mem_write  = 1'b1;
          i_or_d     = 1'b1;
          instr_done = mem_ready;
        end
        S_EXEC_R: begin
          alu_src_a = 1'b1;
          alu_sel   = ALU_FUNC;
        end
        S_R_WB: begin
          reg_write  = 1'b1;
          reg_dst    = 1'b1;
          instr_done = 1'b1;
        end
        S_EXEC_I: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          alu_sel   = ALU_FUNC;
        end
        S_I_WB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a  = 1'b1;
          alu_sel    = ALU_SUB;
          pc_source  = PCSRC_ALUOUT;
          pc_write   = ((op_q == OP_BEQ) && zero) || ((op_q == OP_BNE) && !zero);
          instr_done = 1'b1;
        end
        S_JUMP: begin
          pc_source  = PCSRC_JUMP;
          pc_write   = 1'b1;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS sequencer: state register and opcode latch; the control
// word is decoded by multicycle_ctrl_out.
module multicycle_control
  import multicycle_control_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic [1:0] alu_sel,
  output logic       instr_done,
  output logic       halted,
  output logic [3:0] state
);

  state_t     state_q;
  logic [5:0] op_q;
  logic       halted_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FETCH;
      op_q     <= '0;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH:    if (mem_ready) state_q <= S_DECODE;
        S_DECODE: begin
          op_q    <= op;
          state_q <= decode_next(op);
          if (decode_next(op) == S_HALT) halted_q <= 1'b1;
        end
        S_MEM_ADDR: state_q <= (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD:   if (mem_ready) state_q <= S_MEM_WB;
        S_MEM_WR:   if (mem_ready) state_q <= S_FETCH;
        S_EXEC_R:   state_q <= S_R_WB;
        S_EXEC_I:   state_q <= S_I_WB;
        S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP: state_q <= S_FETCH;
        S_HALT:     state_q <= S_HALT;
        default: begin
          state_q  <= S_HALT;
          halted_q <= 1'b1;
        end
      endcase
    end
  end

  assign state  = rst ? '0 : state_q;
  assign halted = halted_q & ~rst;

  multicycle_ctrl_out u_out (
    .rst        (rst),
    .state      (state_q),
    .op_q       (op_q),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .i_or_d     (i_or_d),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .pc_source  (pc_source),
    .alu_sel    (alu_sel),
    .instr_done (instr_done)
  );

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-instruction state sequences,
// memory wait stalls, branch qualification, halt and mid-access reset.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst, zero, mem_ready;
  logic [5:0] op;
  logic       pc_write, i_or_d, mem_read, mem_write, ir_write, reg_dst;
  logic       mem_to_reg, reg_write, alu_src_a, instr_done, halted;
  logic [1:0] alu_src_b, pc_source, alu_sel;
  logic [3:0] state;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .i_or_d(i_or_d), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .pc_source(pc_source), .alu_sel(alu_sel),
    .instr_done(instr_done), .halted(halted), .state(state)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_ready = 1'b1; op = '0; zero = 1'b0;
    step();
    step();
    checks++;
    if ({pc_write, ir_write, mem_read, state} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs: got pc_write=%b ir_write=%b mem_read=%b state=%0d, want all 0",
               pc_write, ir_write, mem_read, state);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (state !== 4'd0 || halted !== 1'b0 || mem_read !== 1'b1 || alu_src_b !== 2'b01) begin
      errors++;
      $display("FAIL reset_fetch: got state=%0d halted=%b mem_read=%b alu_src_b=%b, want 0 0 1 01",
               state, halted, mem_read, alu_src_b);
    end
  endtask

  task automatic test_rtype();
    logic [3:0] exp_s [4] = '{4'd0, 4'd1, 4'd6, 4'd7};
    int unsigned dones = 0;
    op = 6'h00; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (state !== exp_s[i]) begin
        errors++;
        $display("FAIL rtype_state[%0d]: got %0d want %0d", i, state, exp_s[i]);
      end
      if (i == 2) begin
        checks++;
        if (alu_sel !== 2'b10 || alu_src_a !== 1'b1 || alu_src_b !== 2'b00) begin
          errors++;
          $display("FAIL rtype_exec: got alu_sel=%b src_a=%b src_b=%b want 10 1 00",
                   alu_sel, alu_src_a, alu_src_b);
        end
      end
      if (i == 3) begin
        checks++;
        if (reg_write !== 1'b1 || reg_dst !== 1'b1 || mem_to_reg !== 1'b0) begin
          errors++;
          $display("FAIL rtype_wb: got reg_write=%b reg_dst=%b mem_to_reg=%b want 1 1 0",
                   reg_write, reg_dst, mem_to_reg);
        end
      end
      if (instr_done === 1'b1) dones++;
      step();
    end
    checks++;
    if (state !== 4'd0 || dones != 1) begin
      errors++;
      $display("FAIL rtype_retire: got state=%0d dones=%0d want 0 1", state, dones);
    end
  endtask

  task automatic test_lw_wait();
    logic [3:0] exp_s [7] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4};
    logic       rdy   [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    op = 6'h23;
    for (int i = 0; i < 7; i++) begin
      mem_ready = rdy[i];
      #1;
      checks++;
      if (state !== exp_s[i]) begin
        errors++;
        $display("FAIL lw_state[%0d]: got %0d want %0d", i, state, exp_s[i]);
      end
      checks++;
      if ((reg_write !== (i == 6)) || (mem_to_reg !== (i == 6)) || (instr_done !== (i == 6))) begin
        errors++;
        $display("FAIL lw_wb[%0d]: got reg_write=%b mem_to_reg=%b instr_done=%b want %b",
                 i, reg_write, mem_to_reg, instr_done, (i == 6));
      end
      if (i >= 3 && i <= 5) begin
        checks++;
        if (i_or_d !== 1'b1 || mem_read !== 1'b1 || mem_write !== 1'b0) begin
          errors++;
          $display("FAIL lw_memrd[%0d]: got i_or_d=%b mem_read=%b mem_write=%b want 1 1 0",
                   i, i_or_d, mem_read, mem_write);
        end
      end
      step();
    end
    checks++;
    if (state !== 4'd0) begin
      errors++;
      $display("FAIL lw_end: got state=%0d want 0", state);
    end
  endtask

  task automatic test_branch(input logic [5:0] bop, input logic z, input logic exp_pcw);
    op = bop; zero = z; mem_ready = 1'b1;
    step();
    step();
    checks++;
    if (state !== 4'd8 || pc_write !== exp_pcw || alu_sel !== 2'b01 ||
        pc_source !== 2'b01 || instr_done !== 1'b1) begin
      errors++;
      $display("FAIL branch op=%h zero=%b: got state=%0d pc_write=%b alu_sel=%b pc_source=%b done=%b want 8 %b 01 01 1",
               bop, z, state, pc_write, alu_sel, pc_source, instr_done, exp_pcw);
    end
    step();
    checks++;
    if (state !== 4'd0) begin
      errors++;
      $display("FAIL branch_end op=%h: got state=%0d want 0", bop, state);
    end
    zero = 1'b0;
  endtask

  task automatic test_jump_fetch_wait();
    op = 6'h02; mem_ready = 1'b0;
    #1;
    checks++;
    if (state !== 4'd0 || ir_write !== 1'b0 || pc_write !== 1'b0 || mem_read !== 1'b1) begin
      errors++;
      $display("FAIL fetch_wait: got state=%0d ir_write=%b pc_write=%b mem_read=%b want 0 0 0 1",
               state, ir_write, pc_write, mem_read);
    end
    step();
    mem_ready = 1'b1;
    #1;
    checks++;
    if (state !== 4'd0 || ir_write !== 1'b1 || pc_write !== 1'b1) begin
      errors++;
      $display("FAIL fetch_ready: got state=%0d ir_write=%b pc_write=%b want 0 1 1",
               state, ir_write, pc_write);
    end
    step();
    step();
    checks++;
    if (state !== 4'd9 || pc_write !== 1'b1 || pc_source !== 2'b10 || instr_done !== 1'b1) begin
      errors++;
      $display("FAIL jump: got state=%0d pc_write=%b pc_source=%b done=%b want 9 1 10 1",
               state, pc_write, pc_source, instr_done);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_s [8] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0, 4'd1, 4'd10, 4'd11};
    int unsigned dones = 0;
    mem_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      op = (i < 4) ? 6'h2B : 6'h08;
      #1;
      checks++;
      if (state !== exp_s[i]) begin
        errors++;
        $display("FAIL b2b_state[%0d]: got %0d want %0d", i, state, exp_s[i]);
      end
      if (i == 3) begin
        checks++;
        if (mem_write !== 1'b1 || mem_read !== 1'b0 || i_or_d !== 1'b1) begin
          errors++;
          $display("FAIL sw_write: got mem_write=%b mem_read=%b i_or_d=%b want 1 0 1",
                   mem_write, mem_read, i_or_d);
        end
      end
      if (i == 6) begin
        checks++;
        if (alu_sel !== 2'b10 || alu_src_b !== 2'b10) begin
          errors++;
          $display("FAIL addi_exec: got alu_sel=%b alu_src_b=%b want 10 10", alu_sel, alu_src_b);
        end
      end
      if (instr_done === 1'b1) dones++;
      step();
    end
    checks++;
    if (state !== 4'd0 || dones != 2) begin
      errors++;
      $display("FAIL b2b_retire: got state=%0d dones=%0d want 0 2", state, dones);
    end
  endtask

  task automatic test_halt();
    int unsigned bad = 0;
    op = 6'h3F; mem_ready = 1'b1;
    step();
    step();
    for (int i = 0; i < 12; i++) begin
      if (state !== 4'd12 || halted !== 1'b1 ||
          {pc_write, ir_write, reg_write, mem_write, mem_read, instr_done} !== 6'b0) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL halt_hold: got %0d bad cycles (last state=%0d halted=%b) want 0", bad, state, halted);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (state !== 4'd0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL halt_reset: got state=%0d halted=%b want 0 0", state, halted);
    end
  endtask

  task automatic test_reset_midwrite();
    op = 6'h2B; mem_ready = 1'b1;
    step();
    step();
    step();
    mem_ready = 1'b0;
    #1;
    checks++;
    if (state !== 4'd5 || mem_write !== 1'b1 || instr_done !== 1'b0) begin
      errors++;
      $display("FAIL memwr_wait: got state=%0d mem_write=%b done=%b want 5 1 0", state, mem_write, instr_done);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (mem_write !== 1'b0 || instr_done !== 1'b0) begin
      errors++;
      $display("FAIL memwr_rst: got mem_write=%b done=%b want 0 0", mem_write, instr_done);
    end
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (state !== 4'd0 || mem_write !== 1'b0 || mem_read !== 1'b1) begin
      errors++;
      $display("FAIL memwr_after: got state=%0d mem_write=%b mem_read=%b want 0 0 1", state, mem_write, mem_read);
    end
  endtask

  initial begin
    rst = 1'b1; op = '0; zero = 1'b0; mem_ready = 1'b0;
    #1;
    test_reset();
    test_rtype();
    test_lw_wait();
    test_branch(6'h04, 1'b1, 1'b1);
    test_branch(6'h04, 1'b0, 1'b0);
    test_branch(6'h05, 1'b1, 1'b0);
    test_branch(6'h05, 1'b0, 1'b1);
    test_jump_fetch_wait();
    test_back_to_back();
    test_halt();
    test_reset_midwrite();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
